// File: rtl/scandoubler_ce.sv
// Single-clock 15 kHz -> 31 kHz scan doubler with a pixel clock-enable.
// Each input line fills one half of a ping-pong buffer while the other half is read out twice.
module scandoubler_ce #(
  parameter int CW           = 3,
  parameter int ADDRW        = 10,
  parameter int MIN_LINE     = 128,
  parameter int HSYNC_CYCLES = 80,
  parameter int VSYNC_CYCLES = 2743
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  input  logic             enable_scandoubling,
  input  logic [1:0]       scanline_mode,
  input  logic [CW-1:0]    ri,
  input  logic [CW-1:0]    gi,
  input  logic [CW-1:0]    bi,
  input  logic             hsync_n_in,
  input  logic             vsync_n_in,
  output logic [CW-1:0]    ro,
  output logic [CW-1:0]    go,
  output logic [CW-1:0]    bo,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic [ADDRW-1:0] line_len,
  output logic             locked
);

  localparam int DEPTH = 2 ** ADDRW;
  localparam int PW    = 3 * CW;
  localparam int VSW   = $clog2(VSYNC_CYCLES + 1);

  // Write side
  logic             r_wr_bank;
  logic [ADDRW-1:0] r_wr_cnt;
  logic             r_ovf;
  logic             r_hs_prev;
  logic [ADDRW-1:0] r_line_len;
  logic             r_locked;
  logic             r_swap;
  // Read side
  logic             r_rd_bank;
  logic [ADDRW-1:0] r_rd_cnt;
  logic             r_pass;
  logic [PW-1:0]    r_mem [2*DEPTH];
  logic [PW-1:0]    r_rd_data;
  logic             r_pass_d;
  logic             r_hs_d1;
  // Sync and output registers
  logic             r_vs_prev;
  logic [VSW-1:0]   r_vs_cnt;
  logic [CW-1:0]    r_ro, r_go, r_bo;
  logic             r_hsync_n, r_vsync_n;

  logic w_hs_fall, w_line_end, w_wr_full, w_wr_en, w_rd_last;

  assign w_hs_fall  = pix_ce & r_hs_prev & ~hsync_n_in;
  assign w_line_end = w_hs_fall & (r_wr_cnt >= ADDRW'(MIN_LINE));
  assign w_wr_full  = &r_wr_cnt;
  assign w_wr_en    = pix_ce & ~w_line_end & ~w_wr_full;
  // line_len of 0 means a full 2^ADDRW line, which the modular subtraction gives for free
  assign w_rd_last  = (r_rd_cnt == r_line_len - ADDRW'(1));

  function automatic logic [CW-1:0] f_dim(input logic [CW-1:0] c, input logic [1:0] mode,
                                          input logic pass);
    f_dim = c;
    if (pass) begin
      case (mode)
        2'b01:   f_dim = c - (c >> 2);
        2'b10:   f_dim = c >> 1;
        2'b11:   f_dim = c >> 2;
        default: f_dim = c;
      endcase
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_ovf      <= 1'b0;
      r_hs_prev  <= 1'b1;
      r_line_len <= '0;
      r_locked   <= 1'b0;
      r_swap     <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      r_swap <= w_line_end;
      if (pix_ce) begin
        r_hs_prev <= hsync_n_in;
        if (w_line_end) begin
          r_line_len <= r_wr_cnt;
          r_locked   <= (r_wr_cnt == r_line_len) & ~r_ovf;
          r_ovf      <= 1'b0;
          r_wr_bank  <= ~r_wr_bank;
          r_wr_cnt   <= '0;
        end else if (w_wr_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_wr_cnt <= r_wr_cnt + ADDRW'(1);
        end
      end
    end
  end

  // NOTE: the line buffer has no reset so it maps onto block RAM; only its read register is reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[{r_wr_bank, r_wr_cnt}] <= {ri, gi, bi};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank <= 1'b1;
      r_rd_cnt  <= '0;
      r_pass    <= 1'b0;
      r_rd_data <= '0;
      r_pass_d  <= 1'b0;
      r_hs_d1   <= 1'b1;
    end else begin
      r_rd_data <= r_mem[{r_rd_bank, r_rd_cnt}];
      r_pass_d  <= r_pass;
      r_hs_d1   <= ~(r_rd_cnt < ADDRW'(HSYNC_CYCLES));
      // r_wr_bank has already toggled when r_swap is high, so its inverse is the finished line
      if (r_swap) begin
        r_rd_bank <= ~r_wr_bank;
        r_rd_cnt  <= '0;
        r_pass    <= 1'b0;
      end else if (w_rd_last) begin
        r_rd_cnt <= '0;
        r_pass   <= ~r_pass;
      end else begin
        r_rd_cnt <= r_rd_cnt + ADDRW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b1;
      r_vs_cnt  <= '0;
    end else begin
      r_vs_prev <= vsync_n_in;
      if (r_vs_cnt != '0) r_vs_cnt <= r_vs_cnt - VSW'(1);
      else if (r_vs_prev & ~vsync_n_in) r_vs_cnt <= VSW'(VSYNC_CYCLES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ro      <= '0;
      r_go      <= '0;
      r_bo      <= '0;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
    end else begin
      r_vsync_n <= ~enable_scandoubling | (r_vs_cnt == '0);
      if (enable_scandoubling) begin
        r_ro      <= f_dim(r_rd_data[PW-1 -: CW], scanline_mode, r_pass_d);
        r_go      <= f_dim(r_rd_data[2*CW-1 -: CW], scanline_mode, r_pass_d);
        r_bo      <= f_dim(r_rd_data[CW-1:0], scanline_mode, r_pass_d);
        r_hsync_n <= r_hs_d1;
      end else begin
        r_ro      <= ri;
        r_go      <= gi;
        r_bo      <= bi;
        r_hsync_n <= hsync_n_in & vsync_n_in;
      end
    end
  end

  assign ro       = r_ro;
  assign go       = r_go;
  assign bo       = r_bo;
  assign hsync_n  = r_hsync_n;
  assign vsync_n  = r_vsync_n;
  assign line_len = r_line_len;
  assign locked   = r_locked;

endmodule

// File: tb/tb_scandoubler_ce.sv
// Randomised bench for scandoubler_ce: a line-level reference model predicts every output
// each clock; directed checks cover lock, glitch filter, overflow and vsync length.
module tb_scandoubler_ce;

  localparam int CW       = 3;
  localparam int ADDRW    = 10;
  localparam int MIN_LINE = 128;
  localparam int HSC      = 80;
  localparam int VSC      = 2743;
  localparam int N        = 1 << ADDRW;
  localparam int BASE     = 1 << CW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pix_ce;
  logic             enable_scandoubling;
  logic [1:0]       scanline_mode;
  logic [CW-1:0]    ri, gi, bi;
  logic             hsync_n_in, vsync_n_in;
  logic [CW-1:0]    ro, go, bo;
  logic             hsync_n, vsync_n;
  logic [ADDRW-1:0] line_len;
  logic             locked;

  scandoubler_ce #(
    .CW(CW), .ADDRW(ADDRW), .MIN_LINE(MIN_LINE), .HSYNC_CYCLES(HSC), .VSYNC_CYCLES(VSC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .enable_scandoubling(enable_scandoubling),
    .scanline_mode(scanline_mode), .ri(ri), .gi(gi), .bi(bi),
    .hsync_n_in(hsync_n_in), .vsync_n_in(vsync_n_in),
    .ro(ro), .go(go), .bo(bo), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .line_len(line_len), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: buffer contents, line/bank bookkeeping and the pixel in flight
  int m_mem [2*N];
  bit m_val [2*N];
  int m_wr_bank, m_wr_cnt, m_hs_prev, m_ovf, m_len, m_locked, m_swap;
  int m_rd_bank, m_rd_cnt, m_pass;
  int m_cyc, m_vs_prev, m_vs_start;
  int p_data, p_pass, p_hs_n;
  bit p_val;
  int e_r, e_g, e_b, e_hs, e_vs;
  bit e_cval;

  bit g_en = 1'b1;
  bit g_vs = 1'b1;
  bit g_ce_rand = 1'b0;
  int g_mode = 0;
  int g_vs_low, g_vs_falls;
  bit g_vs_last = 1'b1;

  function automatic int dimm(input int c, input int mode, input int pass);
    if (pass == 0) return c;
    case (mode)
      1:       return c - c / 4;
      2:       return c / 2;
      3:       return c / 4;
      default: return c;
    endcase
  endfunction

  task automatic model_reset();
    m_wr_bank = 0; m_wr_cnt = 0; m_hs_prev = 1; m_ovf = 0; m_len = 0; m_locked = 0; m_swap = 0;
    m_rd_bank = 1; m_rd_cnt = 0; m_pass = 0;
    m_cyc = 0; m_vs_prev = 1; m_vs_start = -1000000;
    p_data = 0; p_val = 1'b1; p_pass = 0; p_hs_n = 1;
    e_r = 0; e_g = 0; e_b = 0; e_hs = 1; e_vs = 1; e_cval = 1'b1;
  endtask

  task automatic model_edge();
    int rd_addr, nd, npass, nhs, old_len, old_bank, mode;
    bit nv, old_swap, line_end, in_win;
    rd_addr  = m_rd_bank * N + m_rd_cnt;
    nd       = m_mem[rd_addr];
    nv       = m_val[rd_addr];
    npass    = m_pass;
    nhs      = (m_rd_cnt < HSC) ? 0 : 1;
    old_len  = m_len;
    old_bank = m_wr_bank;
    old_swap = m_swap != 0;
    line_end = 1'b0;
    mode     = int'(scanline_mode);
    if (enable_scandoubling) begin
      e_r    = dimm(p_data / (BASE * BASE), mode, p_pass);
      e_g    = dimm((p_data / BASE) % BASE, mode, p_pass);
      e_b    = dimm(p_data % BASE, mode, p_pass);
      e_cval = p_val;
      e_hs   = p_hs_n;
    end else begin
      e_r = int'(ri); e_g = int'(gi); e_b = int'(bi);
      e_cval = 1'b1;
      e_hs = (hsync_n_in && vsync_n_in) ? 1 : 0;
    end
    m_cyc++;
    in_win = (m_cyc > m_vs_start) && (m_cyc <= m_vs_start + VSC);
    e_vs = (!enable_scandoubling || !in_win) ? 1 : 0;
    if (!in_win && m_vs_prev == 1 && vsync_n_in == 1'b0) m_vs_start = m_cyc;
    m_vs_prev = int'(vsync_n_in);
    if (pix_ce) begin
      if (m_hs_prev == 1 && hsync_n_in == 1'b0 && m_wr_cnt >= MIN_LINE) begin
        m_locked  = (m_wr_cnt == m_len && m_ovf == 0) ? 1 : 0;
        m_len     = m_wr_cnt;
        m_ovf     = 0;
        m_wr_bank = 1 - m_wr_bank;
        m_wr_cnt  = 0;
        line_end  = 1'b1;
      end else if (m_wr_cnt == N - 1) begin
        m_ovf = 1;
      end else begin
        m_mem[old_bank * N + m_wr_cnt] = int'(ri) * BASE * BASE + int'(gi) * BASE + int'(bi);
        m_val[old_bank * N + m_wr_cnt] = 1'b1;
        m_wr_cnt++;
      end
      m_hs_prev = int'(hsync_n_in);
    end
    if (old_swap) begin
      m_rd_bank = 1 - old_bank;
      m_rd_cnt  = 0;
      m_pass    = 0;
    end else if (m_rd_cnt == ((old_len == 0) ? N : old_len) - 1) begin
      m_rd_cnt = 0;
      m_pass   = 1 - m_pass;
    end else begin
      m_rd_cnt++;
    end
    m_swap = line_end ? 1 : 0;
    p_data = nd; p_val = nv; p_pass = npass; p_hs_n = nhs;
  endtask

  task automatic compare_all();
    if (e_cval) begin
      check("ro", ro, e_r);
      check("go", go, e_g);
      check("bo", bo, e_b);
    end
    check("hsync_n", hsync_n, e_hs);
    check("vsync_n", vsync_n, e_vs);
    check("line_len", line_len, m_len);
    check("locked", locked, m_locked);
    if (!vsync_n) g_vs_low++;
    if (g_vs_last && !vsync_n) g_vs_falls++;
    g_vs_last = vsync_n;
  endtask

  task automatic drive(input bit ce, input bit hs, input int r, input int g, input int b);
    pix_ce = ce; hsync_n_in = hs; vsync_n_in = g_vs;
    ri = CW'(r); gi = CW'(g); bi = CW'(b);
    enable_scandoubling = g_en; scanline_mode = 2'(g_mode);
  endtask

  task automatic step(input bit ce, input bit hs, input int r, input int g, input int b);
    @(negedge clk);
    compare_all();
    drive(ce, hs, r, g, b);
    @(posedge clk);
    if (rst_n) model_edge();
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    repeat (hold) step(1'b0, 1'b1, 0, 0, 0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 0, 0, 0);
    @(posedge clk);
    model_edge();
  endtask

  // One input line: the first strobe carries the hsync falling edge, the rest are stored pixels
  task automatic send_line(input int n, input int kind, input int glitch);
    bit hs;
    int r, g, b, gaps;
    for (int p = 0; p < n; p++) begin
      hs = (p >= 10);
      if (glitch > 0 && p >= glitch && p < glitch + 4) hs = 1'b0;
      case (kind)
        0:       begin r = (p / (BASE * BASE)) % BASE; g = (p / BASE) % BASE; b = p % BASE; end
        2:       begin r = BASE - 1; g = BASE - 1; b = BASE - 1; end
        default: begin r = $urandom_range(BASE - 1); g = $urandom_range(BASE - 1);
                       b = $urandom_range(BASE - 1); end
      endcase
      step(1'b1, hs, r, g, b);
      gaps = g_ce_rand ? $urandom_range(2) : 1;
      for (int k = 0; k < gaps; k++)
        step(1'b0, hs, $urandom_range(BASE - 1), $urandom_range(BASE - 1), $urandom_range(BASE - 1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 0, 0, 0);
    model_reset();
    do_reset(3);

    // Steady 384-pixel lines, ramp colour; lock after the second full measurement
    g_mode = 1;
    repeat (4) send_line(385, 0, 0);
    check("lock_len", line_len, 384);
    check("lock_flag", locked, 1);

    // Dimming sweep on full-scale colour
    for (int m = 0; m < 4; m++) begin
      g_mode = m;
      send_line(385, 2, 0);
    end

    // Glitch filter: edges below MIN_LINE ignored, at MIN_LINE accepted
    send_line(385, 1, 50);
    send_line(385, 1, 0);
    check("glitch50_len", line_len, 384);
    check("glitch50_lock", locked, 1);
    send_line(385, 1, 128);
    send_line(385, 1, 0);
    check("glitch127_len", line_len, 384);
    send_line(385, 1, 129);
    check("glitch128_len", line_len, 128);
    send_line(385, 1, 0);
    send_line(385, 1, 0);

    // Overlong line saturates the write counter
    send_line(1100, 1, 0);
    send_line(385, 0, 0);
    check("ovf_len", line_len, 1023);
    check("ovf_lock", locked, 0);
    send_line(385, 0, 0);
    check("post_ovf_lock", locked, 0);
    send_line(385, 0, 0);
    check("relock", locked, 1);

    // vsync: one window despite a re-trigger during the count
    g_vs_low = 0; g_vs_falls = 0;
    g_vs = 1'b0;
    for (int i = 0; i < 1000; i++) step(i % 2 == 0, 1'b1, 1, 2, 3);
    g_vs = 1'b1;
    for (int i = 0; i < 20; i++) step(i % 2 == 0, 1'b1, 1, 2, 3);
    g_vs = 1'b0;
    for (int i = 0; i < 19000; i++) step(i % 2 == 0, 1'b1, 1, 2, 3);
    g_vs = 1'b1;
    for (int i = 0; i < 10; i++) step(i % 2 == 0, 1'b1, 1, 2, 3);
    check("vs_low_cycles", g_vs_low, VSC);
    check("vs_windows", g_vs_falls, 1);

    // Random line lengths, strobe spacing, colours and modes
    g_ce_rand = 1'b1;
    for (int l = 0; l < 10; l++) begin
      g_mode = $urandom_range(3);
      send_line($urandom_range(500, 140), $urandom_range(2),
                ($urandom_range(3) == 0) ? $urandom_range(200, 20) : 0);
    end

    // Reset in the middle of a line
    send_line(200, 1, 0);
    do_reset(2);
    repeat (3) send_line($urandom_range(400, 200), 1, 0);

    // Passthrough, then back to doubling without resync
    g_en = 1'b0;
    for (int l = 0; l < 4; l++) begin
      g_vs = ($urandom_range(3) != 0);
      send_line($urandom_range(300, 140), 1, 0);
    end
    g_vs = 1'b1;
    g_en = 1'b1;
    repeat (3) send_line(300, 1, 0);

    @(negedge clk);
    compare_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
